// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a block of N 17-bit adder results
// ({carry-out, 16-bit sum}) into an ACC_W-bit total with a sticky overflow
// flag. The total is handed off through a valid/ready result port.
// Optional build macro: ACC_SAT_EN -- saturate the total to all ones on
// overflow instead of wrapping.
module sum_accumulator #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [7:0]       count,
  input  logic             inValid,
  output logic             inReady,
  input  logic [15:0]      sumIn,
  input  logic [3:0]       cOutIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [ACC_W-1:0] accOut,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [7:0]       remaining;
  logic [ACC_W-1:0] acc;
  logic             ovfReg;
  logic [16:0]      sample;
  logic [ACC_W:0]   sumWide;
  logic             startAcc;
  logic             xfer;
  logic             unusedCarries;

  // Only the carry out of bit 15 extends the sample; lower nibble carries are
  // informational and deliberately dropped.
  assign sample        = {cOutIn[3], sumIn};
  assign unusedCarries = ^cOutIn[2:0];

  // One extra bit on the adder exposes the carry that signals overflow.
  always_comb begin
    sumWide = {1'b0, acc} + {{(ACC_W - 16){1'b0}}, sample};
  end

  // State register; reset wins over every other event.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busy      = 1'b0;
    startAcc  = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          startAcc  = 1'b1;
          stateNext = (count == 8'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        inReady = 1'b1;
        busy    = 1'b1;
        if (inValid) begin
          xfer = 1'b1;
          // The final transfer moves to DONE on the same edge it is summed.
          if (remaining == 8'd1) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        outValid = 1'b1;
        busy     = 1'b1;
        if (outReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Accumulator, sticky overflow and remaining-sample counter.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc       <= '0;
      ovfReg    <= 1'b0;
      remaining <= '0;
    end else if (startAcc) begin
      acc       <= '0;
      ovfReg    <= 1'b0;
      remaining <= count;
    end else if (xfer) begin
      remaining <= remaining - 8'd1;
`ifdef ACC_SAT_EN
      if (ovfReg || sumWide[ACC_W]) begin
        acc <= '1;
      end else begin
        acc <= sumWide[ACC_W-1:0];
      end
`else
      acc <= sumWide[ACC_W-1:0];
`endif
      if (sumWide[ACC_W]) begin
        ovfReg <= 1'b1;
      end
    end
  end

  assign accOut = acc;
  assign ovf    = ovfReg;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: randomized and directed checks of sum_accumulator
// against a queue-based arithmetic model of the block total.
module tb_sum_accumulator;

  localparam int unsigned ACC_W = 24;

  logic             Clk;
  logic             Rst_n;
  logic             start;
  logic [7:0]       count;
  logic             inValid;
  logic             inReady;
  logic [15:0]      sumIn;
  logic [3:0]       cOutIn;
  logic             outValid;
  logic             outReady;
  logic [ACC_W-1:0] accOut;
  logic             ovf;
  logic             busy;

  int nChecks = 0;
  int nFails  = 0;

  logic [16:0] sampQ[$];

  sum_accumulator #(.ACC_W(ACC_W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start    (start),
    .count    (count),
    .inValid  (inValid),
    .inReady  (inReady),
    .sumIn    (sumIn),
    .cOutIn   (cOutIn),
    .outValid (outValid),
    .outReady (outReady),
    .accOut   (accOut),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Block total from plain arithmetic over the queued samples.
  task automatic model(output logic [ACC_W-1:0] eAcc, output logic eOvf);
    longint unsigned tot;
    longint unsigned maxVal;
    tot    = 0;
    maxVal = (64'd1 << ACC_W) - 1;
    foreach (sampQ[i]) tot += longint'(sampQ[i]);
    eOvf = (tot > maxVal);
`ifdef ACC_SAT_EN
    eAcc = eOvf ? '1 : tot[ACC_W-1:0];
`else
    eAcc = tot[ACC_W-1:0];
`endif
  endtask

  task automatic stepEdge();
    @(posedge Clk);
    #1;
  endtask

  // Runs one full block from IDLE using sampQ; returns to IDLE.
  task automatic runBlock(input string name, input int bubblePct, input int holdCycles);
    logic [ACC_W-1:0] eAcc;
    logic             eOvf;
    int               n;
    int               idx;
    int               budget;
    n = sampQ.size();
    idx = 0;
    budget = 0;
    model(eAcc, eOvf);

    start    = 1'b1;
    count    = n[7:0];
    inValid  = 1'($urandom);
    outReady = 1'($urandom);
    stepEdge();
    start = 1'b0;
    count = 8'($urandom);
    checkVal({name, " busy"}, 64'(busy), 64'd1);

    if (n == 0) begin
      checkVal({name, " zero outValid"}, 64'(outValid), 64'd1);
      checkVal({name, " zero inReady"}, 64'(inReady), 64'd0);
    end else begin
      checkVal({name, " accum inReady"}, 64'(inReady), 64'd1);
      checkVal({name, " accum outValid"}, 64'(outValid), 64'd0);
      checkVal({name, " cleared acc"}, 64'(accOut), 64'd0);
      while (idx < n && budget < 5000) begin
        inValid = ($urandom_range(99) >= bubblePct);
        sumIn   = sampQ[idx][15:0];
        cOutIn  = {sampQ[idx][16], 3'($urandom)};
        start   = 1'($urandom);
        count   = 8'($urandom);
        stepEdge();
        if (inValid) idx++;
        budget++;
        if (idx < n) begin
          if (inReady !== 1'b1 || outValid !== 1'b0) begin
            checkVal({name, " mid-block ready"}, {62'd0, inReady, outValid}, 64'd2);
          end
        end
      end
      if (idx < n) checkVal({name, " transfer budget"}, 64'(idx), 64'(n));
      inValid = 1'b0;
      start   = 1'b0;
      checkVal({name, " done outValid"}, 64'(outValid), 64'd1);
      checkVal({name, " done inReady"}, 64'(inReady), 64'd0);
    end

    outReady = 1'b0;
    for (int h = 0; h < holdCycles; h++) begin
      inValid = 1'($urandom);
      start   = 1'($urandom);
      sumIn   = 16'($urandom);
      cOutIn  = 4'($urandom);
      count   = 8'($urandom);
      stepEdge();
      checkVal({name, " hold outValid"}, 64'(outValid), 64'd1);
      checkVal({name, " hold acc"}, 64'(accOut), 64'(eAcc));
      checkVal({name, " hold ovf"}, 64'(ovf), 64'(eOvf));
    end
    inValid  = 1'b0;
    start    = 1'b0;
    outReady = 1'b1;
    stepEdge();
    outReady = 1'b0;
    checkVal({name, " idle outValid"}, 64'(outValid), 64'd0);
    checkVal({name, " idle busy"}, 64'(busy), 64'd0);
    checkVal({name, " idle acc"}, 64'(accOut), 64'(eAcc));
    checkVal({name, " idle ovf"}, 64'(ovf), 64'(eOvf));

    // inValid in IDLE must not be consumed.
    inValid = 1'b1;
    sumIn   = 16'hFFFF;
    cOutIn  = 4'hF;
    stepEdge();
    inValid = 1'b0;
    checkVal({name, " idle ignore acc"}, 64'(accOut), 64'(eAcc));
    checkVal({name, " idle inReady"}, 64'(inReady), 64'd0);
  endtask

  initial begin
    logic [16:0] s;
    int          n;

    Rst_n    = 1'b0;
    start    = 1'($urandom);
    count    = 8'($urandom);
    inValid  = 1'($urandom);
    sumIn    = 16'($urandom);
    cOutIn   = 4'($urandom);
    outReady = 1'($urandom);
    stepEdge();
    start    = 1'($urandom);
    inValid  = 1'($urandom);
    stepEdge();
    checkVal("reset acc", 64'(accOut), 64'd0);
    checkVal("reset ovf", 64'(ovf), 64'd0);
    checkVal("reset inReady", 64'(inReady), 64'd0);
    checkVal("reset outValid", 64'(outValid), 64'd0);
    checkVal("reset busy", 64'(busy), 64'd0);
    Rst_n   = 1'b1;
    start   = 1'b0;
    inValid = 1'b0;
    stepEdge();

    // Three-sample directed block.
    sampQ = {17'h00000, 17'h0FFFF, 17'h1FFFE};
    runBlock("three", 0, 1);
    checkVal("three const acc", 64'(accOut), 64'h02FFFD);
    checkVal("three const ovf", 64'(ovf), 64'd0);

    // Empty block.
    sampQ.delete();
    runBlock("empty", 0, 1);
    checkVal("empty const acc", 64'(accOut), 64'd0);

    // Overflowing block of 200 maximal samples.
    sampQ.delete();
    for (int i = 0; i < 200; i++) sampQ.push_back(17'h1FFFF);
    runBlock("ovf200", 0, 2);
    checkVal("ovf200 const ovf", 64'(ovf), 64'd1);
`ifdef ACC_SAT_EN
    checkVal("ovf200 const acc", 64'(accOut), 64'hFFFFFF);
`else
    checkVal("ovf200 const acc", 64'(accOut), 64'h8FFF38);
`endif

    // Long stall in DONE.
    sampQ = {17'h00123, 17'h1ABCD};
    runBlock("stall", 30, 5);

    // Random blocks with bubbles.
    for (int b = 0; b < 8; b++) begin
      sampQ.delete();
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) begin
        s = 17'($urandom);
        sampQ.push_back(s);
      end
      runBlock("rand", 40, $urandom_range(3, 1));
    end

    // Random large-sample blocks that may overflow.
    for (int b = 0; b < 3; b++) begin
      sampQ.delete();
      n = $urandom_range(255, 100);
      for (int i = 0; i < n; i++) begin
        s = 17'($urandom_range(17'h1FFFF, 17'h10000));
        sampQ.push_back(s);
      end
      runBlock("randbig", 10, 1);
    end

    // Reset in the middle of a block.
    start   = 1'b1;
    count   = 8'd4;
    stepEdge();
    start   = 1'b0;
    inValid = 1'b1;
    sumIn   = 16'h1111;
    cOutIn  = 4'h8;
    stepEdge();
    stepEdge();
    Rst_n = 1'b0;
    stepEdge();
    Rst_n   = 1'b1;
    inValid = 1'b0;
    checkVal("midrst acc", 64'(accOut), 64'd0);
    checkVal("midrst ovf", 64'(ovf), 64'd0);
    checkVal("midrst inReady", 64'(inReady), 64'd0);
    checkVal("midrst outValid", 64'(outValid), 64'd0);
    checkVal("midrst busy", 64'(busy), 64'd0);
    stepEdge();
    sampQ = {17'h00005};
    runBlock("afterrst", 0, 1);
    checkVal("afterrst const acc", 64'(accOut), 64'h000005);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
